// File: rtl/audio_mul_pkg.sv
// Shared widths, saturation limits and helpers for the audio gain multiplier
// scheduler and its round-robin arbiter.
package audio_mul_pkg;

    localparam int SAMPLE_W = 24;
    localparam int GAIN_W   = 12;
    localparam int PROD_W   = 36;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [GAIN_W-1:0]   gain_t;

    localparam sample_t SAT_MAX = 24'sh7FFFFF;
    localparam sample_t SAT_MIN = 24'sh800000;

    // Gain code that represents 1.0 for a given number of fractional bits.
    function automatic gain_t UNITY_GAIN(input int frac);
        return GAIN_W'(1 << frac);
    endfunction

endpackage

// File: rtl/audio_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// moves the pointer just past the winner whenever a grant is consumed.
module audio_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] rr_ptr_next;
    logic [IW:0]   cand;
    logic          found;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (advance) begin
            rr_ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/audio_gain_mul_sched.sv
// Time-shares one signed 24x12 gain multiplier among N_REQ requesters through
// a two-stage pipeline; results are rounded half-up, saturated and tagged.
module audio_gain_mul_sched
    import audio_mul_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int FRAC_BITS = 10,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*SAMPLE_W-1:0] req_sample,
    input  logic [N_REQ*GAIN_W-1:0]   req_gain,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAMPLE_W-1:0]       out_data,
    output logic [IDW-1:0]            out_id,
    output logic                      out_sat
);

    localparam logic signed [PROD_W:0] ROUND_BIAS = (PROD_W+1)'(2 ** (FRAC_BITS - 1));
    localparam logic signed [PROD_W:0] SAT_MAX_X  = (PROD_W+1)'(SAT_MAX);
    localparam logic signed [PROD_W:0] SAT_MIN_X  = (PROD_W+1)'(SAT_MIN);

    sample_t sample_arr [N_REQ];
    gain_t   gain_arr   [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign sample_arr[gi] = req_sample[gi*SAMPLE_W +: SAMPLE_W];
            assign gain_arr[gi]   = req_gain[gi*GAIN_W +: GAIN_W];
        end
    endgenerate

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             s1_adv;
    logic             s2_adv;

    logic             s1_valid_reg;
    sample_t          s1_sample_reg;
    gain_t            s1_gain_reg;
    logic [IDW-1:0]   s1_id_reg;

    logic             out_valid_reg;
    sample_t          out_data_reg;
    logic [IDW-1:0]   out_id_reg;
    logic             out_sat_reg;

    audio_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign s2_adv    = !out_valid_reg || out_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    // Gating with reset keeps the handshake quiet while stale state is flushed.
    assign req_ready = grant & {N_REQ{s1_adv & ap_rst_n}};
    assign accept    = |(req_valid & req_ready);

    logic signed [PROD_W-1:0] sample_x;
    logic signed [PROD_W-1:0] gain_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W:0]   rounded;
    logic signed [PROD_W:0]   shifted;
    sample_t                  sat_data;
    logic                     sat_flag;

    assign sample_x = PROD_W'(s1_sample_reg);
    assign gain_x   = PROD_W'(s1_gain_reg);
    assign prod     = sample_x * gain_x;
    assign rounded  = (PROD_W+1)'(prod) + ROUND_BIAS;
    assign shifted  = rounded >>> FRAC_BITS;

    always_comb begin
        sat_data = shifted[SAMPLE_W-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_MAX_X) begin
            sat_data = SAT_MAX;
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN_X) begin
            sat_data = SAT_MIN;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sample_reg <= '0;
            s1_gain_reg   <= '0;
            s1_id_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_sample_reg <= sample_arr[grant_idx];
                    s1_gain_reg   <= gain_arr[grant_idx];
                    s1_id_reg     <= grant_idx;
                end
            end
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= sat_data;
                    out_id_reg   <= s1_id_reg;
                    out_sat_reg  <= sat_flag;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_audio_gain_mul_sched.sv
// Self-checking bench: directed vector table, round-robin/sparse/backpressure/
// reset sequences and a random stream against an arithmetic scoreboard model.
module tb_audio_gain_mul_sched;
    import audio_mul_pkg::*;

    localparam int N    = 4;
    localparam int FRAC = 10;
    localparam int IDW  = $clog2(N);

    logic                 ap_clk;
    logic                 ap_rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*24-1:0]      req_sample;
    logic [N*12-1:0]      req_gain;
    logic                 out_valid;
    logic                 out_ready;
    logic [23:0]          out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_sat;

    audio_gain_mul_sched #(.N_REQ(N), .FRAC_BITS(FRAC)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sample (req_sample),
        .req_gain   (req_gain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_sat    (out_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [23:0]    data;
        logic [IDW-1:0] id;
        logic           sat;
        int             acc;
    } exp_t;

    typedef struct {
        logic [23:0] sample;
        logic [11:0] gain;
        logic [23:0] exp_data;
        logic        exp_sat;
    } vec_t;

    exp_t        sbq[$];
    int          pop_ids[$];
    logic [23:0] smp [N];
    logic [11:0] gn  [N];
    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          edges    = 0;
    int          rr_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference arithmetic: exact product, add half an LSB, floor-divide, clip.
    function automatic exp_t model_mul(input logic [23:0] s, input logic [11:0] g);
        exp_t   e;
        longint p, q;
        p = longint'($signed(s)) * longint'(g);
        q = (p + longint'(1 << (FRAC - 1))) >>> FRAC;
        e.acc = 0;
        e.id  = '0;
        if (q > 64'sd8388607) begin
            e.data = 24'h7FFFFF; e.sat = 1'b1;
        end else if (q < -64'sd8388608) begin
            e.data = 24'h800000; e.sat = 1'b1;
        end else begin
            e.data = q[23:0];    e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(rr_model + k) % N]) return (rr_model + k) % N;
        end
        return 0;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            smp[i] = 24'($urandom());
            gn[i]  = 12'($urandom_range(4095, 0));
        end
    endtask

    // One clock cycle: drive at edge+1, check at edge+3, then advance.
    task automatic drive_cycle(input logic [N-1:0] v, input logic ordy);
        logic [N-1:0] exp_ready;
        logic         exp_ov;
        int           g;
        exp_t         e;
        for (int i = 0; i < N; i++) begin
            req_sample[i*24 +: 24] = smp[i];
            req_gain[i*12 +: 12]   = gn[i];
        end
        req_valid = v;
        out_ready = ordy;
        #2;
        exp_ov = (sbq.size() > 0) && (sbq[0].acc <= edges - 1);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_data", 32'(out_data), 32'(sbq[0].data));
            check("out_id",   32'(out_id),   32'(sbq[0].id));
            check("out_sat",  32'(out_sat),  32'(sbq[0].sat));
        end
        g = model_grant(v);
        exp_ready = '0;
        if (v != '0 && (sbq.size() < 2 || ordy)) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_ov && ordy) begin
            e = sbq.pop_front();
            pop_ids.push_back(int'(e.id));
            $display("txn t=%0t id=%0d data=%06h sat=%0d", $time, e.id, e.data, e.sat);
        end
        if (exp_ready != '0) begin
            e = model_mul(smp[g], gn[g]);
            e.id  = IDW'(g);
            e.acc = edges + 1;
            sbq.push_back(e);
            rr_model = (g + 1) % N;
        end
        @(posedge ap_clk);
        edges++;
        #1;
    endtask

    task automatic do_reset(input int ncyc, input logic [N-1:0] v);
        ap_rst_n = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            req_valid = v;
            out_ready = 1'b1;
            #2;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            @(posedge ap_clk);
            edges++;
            #1;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data",  32'(out_data),  32'd0);
            check("rst_out_id",    32'(out_id),    32'd0);
            check("rst_out_sat",   32'(out_sat),   32'd0);
        end
        ap_rst_n = 1'b1;
        sbq.delete();
        rr_model = 0;
    endtask

    initial begin
        int sparse_exp [12];
        sparse_exp = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 1, 1, 1};

        vecs[0] = '{24'h123456, UNITY_GAIN(FRAC), 24'h123456, 1'b0};
        vecs[1] = '{24'h500000, 12'd2048, 24'h7FFFFF, 1'b1};
        vecs[2] = '{24'h900000, 12'd4095, 24'h800000, 1'b1};
        vecs[3] = '{24'hFFFFFF, 12'd512,  24'h000000, 1'b0};
        vecs[4] = '{24'hFFFFFF, 12'd1536, 24'hFFFFFF, 1'b0};
        vecs[5] = '{24'h000003, 12'd341,  24'h000001, 1'b0};
        vecs[6] = '{24'h7FFFFF, 12'd1024, 24'h7FFFFF, 1'b0};
        vecs[7] = '{24'h800000, 12'd1024, 24'h800000, 1'b0};
        vecs[8] = '{24'h400000, 12'd2047, 24'h7FF000, 1'b0};
        vecs[9] = '{24'h000001, 12'd0,    24'h000000, 1'b0};

        ap_rst_n   = 1'b0;
        req_valid  = '0;
        out_ready  = 1'b0;
        req_sample = '0;
        req_gain   = '0;
        for (int i = 0; i < N; i++) begin smp[i] = '0; gn[i] = '0; end
        @(posedge ap_clk);
        #1;
        do_reset(2, '1);

        // Directed vectors on requester 0, result two edges after accept.
        for (int k = 0; k < 10; k++) begin
            smp[0] = vecs[k].sample;
            gn[0]  = vecs[k].gain;
            drive_cycle(4'b0001, 1'b1);
            drive_cycle(4'b0000, 1'b1);
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", k),  32'(out_data),  32'(vecs[k].exp_data));
            check($sformatf("vec%0d_id", k),    32'(out_id),    32'd0);
            check($sformatf("vec%0d_sat", k),   32'(out_sat),   32'(vecs[k].exp_sat));
            drive_cycle(4'b0000, 1'b1);
        end

        // Round-robin under full demand.
        do_reset(1, '0);
        pop_ids.delete();
        for (int c = 0; c < 12; c++) begin rand_ops(); drive_cycle('1, 1'b1); end
        for (int c = 0; c < 3; c++) drive_cycle('0, 1'b1);
        check("rr_count", 32'(pop_ids.size()), 32'd12);
        for (int k = 0; k < pop_ids.size() && k < 12; k++)
            check($sformatf("rr_id%0d", k), 32'(pop_ids[k]), 32'(k % N));

        // Sparse requesters 1 and 3, then only 1.
        pop_ids.delete();
        for (int c = 0; c < 8; c++) begin rand_ops(); drive_cycle(4'b1010, 1'b1); end
        for (int c = 0; c < 4; c++) begin rand_ops(); drive_cycle(4'b0010, 1'b1); end
        for (int c = 0; c < 3; c++) drive_cycle('0, 1'b1);
        check("sparse_count", 32'(pop_ids.size()), 32'd12);
        for (int k = 0; k < pop_ids.size() && k < 12; k++)
            check($sformatf("sparse_id%0d", k), 32'(pop_ids[k]), 32'(sparse_exp[k]));

        // Backpressure: five stalled cycles mid-stream.
        for (int c = 0; c < 4; c++) begin rand_ops(); drive_cycle('1, 1'b1); end
        for (int c = 0; c < 5; c++) begin rand_ops(); drive_cycle('1, 1'b0); end
        for (int c = 0; c < 8; c++) begin rand_ops(); drive_cycle('1, 1'b1); end
        for (int c = 0; c < 4; c++) drive_cycle('0, 1'b1);
        check("bp_drained", 32'(sbq.size()), 32'd0);

        // Random traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            drive_cycle(N'($urandom()), ($urandom_range(3, 0) != 0));
        end
        for (int c = 0; c < 4; c++) drive_cycle('0, 1'b1);
        check("rand_drained", 32'(sbq.size()), 32'd0);

        // Reset with both stages full; first grant goes to the lowest valid.
        for (int c = 0; c < 2; c++) begin rand_ops(); drive_cycle('1, 1'b1); end
        for (int c = 0; c < 2; c++) begin rand_ops(); drive_cycle('1, 1'b0); end
        check("pre_rst_full", 32'(sbq.size()), 32'd2);
        do_reset(2, 4'b1110);
        pop_ids.delete();
        rand_ops();
        drive_cycle(4'b1110, 1'b1);
        for (int c = 0; c < 3; c++) drive_cycle('0, 1'b1);
        check("post_rst_count", 32'(pop_ids.size()), 32'd1);
        if (pop_ids.size() > 0) check("post_rst_id", 32'(pop_ids[0]), 32'd1);
        check("final_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_gain_mul_sched.md
# audio_gain_mul_sched

Round-robin scheduler that time-shares one signed 24-bit × unsigned 12-bit gain multiplier among `N_REQ` audio requesters (channels or effect stages) in the master audio control path. Each requester offers a sample/gain pair over a valid/ready handshake. The block multiplies them, rounds and saturates the product back to 24 bits, and returns the result on a single tagged output stream. It sits between the per-channel effect stages and the AXIS output formatter. It sustains one product per cycle with no bubbles under continuous demand.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `FRAC_BITS`, 10, fractional bits of the gain (Q2.10; unity = 1024)
- `ap_clk` in 1 — single clock, all logic rising-edge
- `ap_rst_n` in 1 — reset, synchronous, active-low
- `req_valid` in N_REQ — per-requester operand valid
- `req_ready` out N_REQ — per-requester accept; at most one bit high per cycle
- `req_sample` in N_REQ×24 — signed two's-complement samples, requester i at bits [24i+23:24i]
- `req_gain` in N_REQ×12 — unsigned gains, requester i at bits [12i+11:12i]
- `out_valid` out 1 — result valid
- `out_ready` in 1 — downstream accept
- `out_data` out 24 — signed rounded, saturated product
- `out_id` out clog2(N_REQ) — index of the originating requester
- `out_sat` out 1 — high when `out_data` was clipped

## Operation
- **Accept.** A request from i is accepted when `req_valid[i] && req_ready[i]`.
  - `req_ready[i] = grant[i] && s1_adv`.
  - `req_ready` may depend combinationally on `req_valid`. `req_valid` never depends on `req_ready`.
- **Arbitration.** Round-robin from pointer `rr_ptr`.
  - `grant` is the first valid requester at or after `rr_ptr`, with wrap-around.
  - On an accept from i, `rr_ptr` moves to (i+1) mod N_REQ.
  - With no accept, `rr_ptr` holds.
  - A requester whose valid drops before acceptance loses its turn. No state is kept for it.
- **Stage 1 (operand register).** Holds sample, gain, id and `s1_valid`.
- **Stage 2 (output register).** Drives `out_*`.
- **Advance rules.**
  - `s2_adv = !out_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - Stage 2 loads from stage 1 when `s2_adv`. `out_valid` takes `s1_valid`.
- **Arithmetic** (combinational between S1 and S2).
  - `prod` is 36-bit signed: sample × {0, gain}.
  - `r` is 37-bit: `prod + 2^(FRAC_BITS-1)`. This is round-half-up.
  - Result is `r >>> FRAC_BITS`, an arithmetic shift.
  - If the result is > 8388607, `out_data = 0x7FFFFF` and `out_sat = 1`.
  - If the result is < −8388608, `out_data = 0x800000` and `out_sat = 1`.
  - Otherwise `out_data` is the low 24 bits of the result and `out_sat = 0`.
- **Ordering.** Results leave in acceptance order. None are dropped or duplicated.

## Timing
- **Latency.** An accept at edge t is visible on `out_*` after edge t+1, i.e. 2 cycles when unstalled.
- **Throughput.** 1 result per cycle while `out_ready = 1`.
- **Stall.** While `out_valid && !out_ready`:
  - `out_data`, `out_id` and `out_sat` are held stable.
  - Stage 1 holds if full, so `req_ready` is all-zero.
  - Stage 1 may still fill one more entry if it was empty.
- **Simultaneous accept and drain.** Both occur in the same cycle with no bubble.
- **Reset.** While `ap_rst_n = 0` at an edge:
  - `s1_valid` = 0, `out_valid` = 0.
  - `out_data` = 0, `out_id` = 0, `out_sat` = 0.
  - `rr_ptr` = 0.
  - `req_ready` is all-zero while reset is asserted.
- **Reset mid-operation.** In-flight results are discarded. The first cycle after release grants the lowest-index valid requester.

## Structure
- **Package `audio_mul_pkg`:**
  - `SAMPLE_W` = 24, `GAIN_W` = 12, `PROD_W` = 36.
  - `SAT_MAX` / `SAT_MIN` constants.
  - `UNITY_GAIN(frac)` function.
  - `sample_t` / `gain_t` typedefs.
- **Sub-module `audio_rr_arbiter`** (parameter `N`).
  - Inputs: `req` vector and `advance` strobe.
  - Output: one-hot `grant` and encoded index.
  - Owns `rr_ptr`.
- The multiply/round/saturate logic stays inline in the top module.

## Test plan
- **Unity gain.** Requester 0 sends 0x123456 with gain 1024 → `out_data` 0x123456, `out_id` 0, `out_sat` 0, two cycles after the accept.
- **Saturation and rounding.**
  - 0x500000 × 2048 → 0x7FFFFF with `out_sat` 1.
  - 0x900000 × 4095 → 0x800000 with `out_sat` 1.
  - 0xFFFFFF (−1) × 512 → 0x000000 (round half up).
- **Round-robin.** All 4 requesters hold valid continuously with `out_ready` = 1 → `out_id` sequence 0,1,2,3,0,1… with one result per cycle and no gaps.
- **Backpressure.**
  - Stimulus: `out_ready` low for 5 cycles during the stream.
  - `out_*` is held stable and `req_ready` is all-zero once stage 1 is full.
  - After release there is no loss or reordering against a scoreboard.
- **Sparse requests.** Only requesters 1 and 3 valid → alternates 1,3,1,3. When 3 drops valid, 1 gets every cycle.
- **Mid-stream reset.** Drive `ap_rst_n` = 0 for 2 cycles with both stages full.
  - `out_valid` reads 0 after the first reset edge.
  - The first post-reset grant goes to the lowest-index valid requester.
